// File: rtl/led_port_arbiter_if.sv
// Request/ack bus between the two LED writers and the LED port arbiter.
interface led_port_arbiter_if #(
   parameter int unsigned DATA_W = 8
);
   logic              req0;
   logic [DATA_W-1:0] data0;
   logic              ack0;
   logic              req1;
   logic [DATA_W-1:0] data1;
   logic              ack1;
   logic [DATA_W-1:0] led;
   logic              busy;
   logic              last_grant;
   logic [7:0]        gcnt0;
   logic [7:0]        gcnt1;

   // Writer side: drives requests and data, observes acks and LED state.
   modport master (
      output req0, data0, req1, data1,
      input  ack0, ack1, led, busy, last_grant, gcnt0, gcnt1
   );

   // Arbiter side.
   modport slave (
      input  req0, data0, req1, data1,
      output ack0, ack1, led, busy, last_grant, gcnt0, gcnt1
   );
endinterface

// File: rtl/led_port_arbiter.sv
// Round-robin arbiter sharing the LED port between the core (0) and a debug
// writer (1); each accepted value is held for MIN_HOLD cycles before the next.
module led_port_arbiter #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       MIN_HOLD  = 4,   // legal range 1..255
   parameter logic [DATA_W-1:0] RESET_LED = '0
) (
   input logic              clk,
   input logic              rst,
   led_port_arbiter_if.slave bus
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [7:0] HOLD_INIT = 8'(MIN_HOLD - 1);
   localparam logic [7:0] CNT_MAX   = 8'hFF;

   state_t            state;
   logic [7:0]        hold_cnt;
   logic [DATA_W-1:0] led;
   logic              ack0;
   logic              ack1;
   logic              busy;
   logic              last_grant;
   logic [7:0]        gcnt0;
   logic [7:0]        gcnt1;
   logic              any_req;
   logic              grant;

   // Pick the requester: the sole one, or the one not granted last on a tie.
   always_comb begin
      any_req = bus.req0 | bus.req1;
      grant   = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
   end

   // Arbitration FSM with registered LED, ack, busy and grant counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         hold_cnt   <= 8'd0;
         led        <= RESET_LED;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
         last_grant <= 1'b1;
         gcnt0      <= 8'd0;
         gcnt1      <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               ack0 <= 1'b0;
               ack1 <= 1'b0;
               busy <= 1'b0;
               if (any_req) begin
                  state      <= HOLD;
                  hold_cnt   <= HOLD_INIT;
                  busy       <= 1'b1;
                  last_grant <= grant;
                  if (grant) begin
                     led  <= bus.data1;
                     ack1 <= 1'b1;
                     if (gcnt1 != CNT_MAX) gcnt1 <= gcnt1 + 8'd1;
                  end else begin
                     led  <= bus.data0;
                     ack0 <= 1'b1;
                     if (gcnt0 != CNT_MAX) gcnt0 <= gcnt0 + 8'd1;
                  end
               end
            end
            HOLD: begin
               // Ack covers only the first HOLD cycle; requests are ignored here.
               ack0 <= 1'b0;
               ack1 <= 1'b0;
               if (hold_cnt == 8'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               ack0  <= 1'b0;
               ack1  <= 1'b0;
            end
         endcase
      end
   end

   // Drive the bus from the registered state only.
   assign bus.led        = led;
   assign bus.ack0       = ack0;
   assign bus.ack1       = ack1;
   assign bus.busy       = busy;
   assign bus.last_grant = last_grant;
   assign bus.gcnt0      = gcnt0;
   assign bus.gcnt1      = gcnt1;

endmodule

// File: tb/tb_led_port_arbiter.sv
// Scoreboard bench for led_port_arbiter: stimulus pushes expected grants,
// a negedge monitor pops and compares on every ack.
module tb_led_port_arbiter;

   typedef struct {
      bit       idx;
      bit [7:0] led;
      bit [7:0] gcnt;
      int       gap;   // required edges since previous ack, 0 = don't care
   } exp_t;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_ack_cyc = 0;
   int   exp_g0 = 0;
   int   exp_g1 = 0;
   exp_t sb[$];
   exp_t mon_e;
   bit   ok;
   int   n;

   led_port_arbiter_if #(.DATA_W(8)) bus ();

   led_port_arbiter #(.DATA_W(8), .MIN_HOLD(4), .RESET_LED(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input bit idx, input bit [7:0] d, input int gap);
      exp_t e;
      if (idx) begin
         if (exp_g1 < 255) exp_g1++;
         e.gcnt = 8'(exp_g1);
      end else begin
         if (exp_g0 < 255) exp_g0++;
         e.gcnt = 8'(exp_g0);
      end
      e.idx = idx;
      e.led = d;
      e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic wait_ack(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.ack0 || bus.ack1) begin
            got = 1'b1;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL ack_timeout: no ack within 20 cycles, want ack (t=%0t)", $time);
   endtask

   // Monitor: every ack must match the next scoreboard entry.
   always @(negedge clk) begin
      if (!rst && (bus.ack0 || bus.ack1)) begin
         check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: ack0=%0b ack1=%0b, want no ack", bus.ack0, bus.ack1);
         end else begin
            mon_e = sb.pop_front();
            check("grant_idx", 32'(bus.ack1), 32'(mon_e.idx));
            check("led", 32'(bus.led), 32'(mon_e.led));
            check("gcnt", 32'(mon_e.idx ? bus.gcnt1 : bus.gcnt0), 32'(mon_e.gcnt));
            check("last_grant", 32'(bus.last_grant), 32'(mon_e.idx));
            check("busy_in_ack", 32'(bus.busy), 32'd1);
            if (mon_e.gap != 0) check("ack_gap", 32'(cyc - last_ack_cyc), 32'(mon_e.gap));
         end
         last_ack_cyc <= cyc;
      end
   end

   initial begin
      bus.req0  = 1'b0;
      bus.req1  = 1'b0;
      bus.data0 = 8'h00;
      bus.data1 = 8'h00;
      rst       = 1'b0;

      // 1: asynchronous reset values, checked before any clock edge
      #2 rst = 1'b1;
      #1;
      check("rst_led", 32'(bus.led), 32'h00);
      check("rst_ack0", 32'(bus.ack0), 32'd0);
      check("rst_ack1", 32'(bus.ack1), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_gcnt0", 32'(bus.gcnt0), 32'd0);
      check("rst_gcnt1", 32'(bus.gcnt1), 32'd0);
      check("rst_last_grant", 32'(bus.last_grant), 32'd1);
      @(negedge clk) rst = 1'b0;

      // 2: single core write, busy for exactly MIN_HOLD cycles
      @(negedge clk);
      bus.data0 = 8'hA5;
      bus.req0  = 1'b1;
      push(1'b0, 8'hA5, 0);
      wait_ack(ok);
      bus.req0 = 1'b0;
      n = 0;
      while (bus.busy && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(n), 32'd4);
      check("led_held", 32'(bus.led), 32'hA5);
      check("ack0_dropped", 32'(bus.ack0), 32'd0);

      // 3: both requesting from reset, alternating grants 5 edges apart
      @(negedge clk) rst = 1'b1;
      exp_g0 = 0;
      exp_g1 = 0;
      @(negedge clk) rst = 1'b0;
      bus.data0 = 8'h11;
      bus.data1 = 8'h22;
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      push(1'b0, 8'h11, 0);
      push(1'b1, 8'h22, 5);
      push(1'b0, 8'h11, 5);
      push(1'b1, 8'h22, 5);
      for (int k = 0; k < 4; k++) begin
         bit was1;
         wait_ack(ok);
         if (!ok) break;
         was1 = bus.ack1;
         if (was1) bus.req1 = 1'b0;
         else      bus.req0 = 1'b0;
         @(negedge clk);
         if (k < 2) begin
            if (was1) bus.req1 = 1'b1;
            else      bus.req0 = 1'b1;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (6) @(negedge clk);

      // 4: debug request raised during HOLD is served on the first IDLE edge
      bus.data0 = 8'h5A;
      bus.req0  = 1'b1;
      push(1'b0, 8'h5A, 0);
      wait_ack(ok);
      bus.req0 = 1'b0;
      @(negedge clk);
      bus.data1 = 8'h3C;
      bus.req1  = 1'b1;
      push(1'b1, 8'h3C, 5);
      wait_ack(ok);
      bus.req1 = 1'b0;
      check("led_debug", 32'(bus.led), 32'h3C);
      repeat (6) @(negedge clk);

      // 5: reset in the second HOLD cycle, then normal service
      bus.data0 = 8'hC3;
      bus.req0  = 1'b1;
      push(1'b0, 8'hC3, 0);
      wait_ack(ok);
      bus.req0 = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midhold_led", 32'(bus.led), 32'h00);
      check("midhold_busy", 32'(bus.busy), 32'd0);
      check("midhold_gcnt0", 32'(bus.gcnt0), 32'd0);
      exp_g0 = 0;
      exp_g1 = 0;
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      bus.data0 = 8'h99;
      bus.req0  = 1'b1;
      push(1'b0, 8'h99, 0);
      wait_ack(ok);
      bus.req0 = 1'b0;
      repeat (6) @(negedge clk);

      // 6: 300 lone core grants, counter saturates at 255
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         bus.data0 = 8'(i);
         bus.req0  = 1'b1;
         push(1'b0, 8'(i), (i == 0) ? 0 : 5);
         wait_ack(ok);
         bus.req0 = 1'b0;
         if (!ok) break;
      end
      repeat (6) @(negedge clk);
      check("sat_gcnt0", 32'(bus.gcnt0), 32'd255);
      check("sat_gcnt1", 32'(bus.gcnt1), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
